// File: rtl/fp32_to_fixed_conv.sv
// IEEE-754 single to signed Q(INT_W.FRAC_W) converter: iterative one-bit-per-cycle
// shifter with guard/sticky tracking, four rounding modes and saturation.
module fp32_to_fixed_conv #(
    parameter int INT_W  = 16,
    parameter int FRAC_W = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_data,
    input  logic [1:0]                in_rmode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [INT_W+FRAC_W-1:0]   out_data,
    output logic [2:0]                out_flags
);

    localparam int W  = INT_W + FRAC_W;
    // Working magnitude keeps at least the 24-bit significand plus one headroom bit.
    localparam int MW = (W > 24) ? (W + 1) : 25;
    localparam int CW = 12;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINAL,
        DONE
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic          sign_reg;
    logic [1:0]    rmode_reg;
    logic [MW-1:0] mag_reg;
    logic          guard_reg;
    logic          sticky_reg;
    logic          ovf_reg;
    logic          nan_reg;
    logic          flush_reg;
    logic          left_reg;
    logic [CW-1:0] cnt_reg;
    logic [W-1:0]  out_data_reg;
    logic [2:0]    out_flags_reg;

    // ------------------------------------------------------------------
    // Input classification
    // ------------------------------------------------------------------
    logic [7:0]           exp_in;
    logic [22:0]          man_in;
    logic signed [CW-1:0] s_in;
    logic                 exp_max;
    logic                 exp_zero;
    logic                 is_nan;
    logic                 is_inf;
    logic                 is_big;
    logic                 is_tiny;
    logic                 special;
    logic [CW-1:0]        shift_amt;
    logic [MW-1:0]        mag_init;
    logic                 sticky_init;
    logic                 ovf_init;

    assign exp_in   = in_data[30:23];
    assign man_in   = in_data[22:0];
    assign s_in     = $signed({{(CW-8){1'b0}}, exp_in}) - $signed(CW'(150))
                      + $signed(CW'(FRAC_W));
    assign exp_max  = (exp_in == 8'hFF);
    assign exp_zero = (exp_in == 8'h00);
    assign is_nan   = exp_max && (man_in != 23'd0);
    assign is_inf   = exp_max && (man_in == 23'd0);
    assign is_big   = !exp_max && !exp_zero && (s_in >= $signed(CW'(W)));
    assign is_tiny  = !exp_max && !exp_zero && (s_in <= -$signed(CW'(26)));
    assign special  = exp_max || exp_zero || is_big || is_tiny;

    always_comb begin
        shift_amt   = '0;
        mag_init    = '0;
        sticky_init = 1'b0;
        ovf_init    = 1'b0;
        if (!special) begin
            shift_amt = s_in[CW-1] ? CW'(-s_in) : CW'(s_in);
            mag_init  = MW'({1'b1, man_in});
        end
        if (exp_zero) begin
            sticky_init = (man_in != 23'd0);
        end
        if (is_tiny) begin
            sticky_init = 1'b1;
        end
        if (is_inf || is_big) begin
            ovf_init = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Saturation masks
    // ------------------------------------------------------------------
    logic [MW:0]  pos_lim;
    logic [MW:0]  neg_lim;
    logic [W-1:0] sat_pos;
    logic [W-1:0] sat_neg;

    genvar gi;
    generate
        for (gi = 0; gi <= MW; gi++) begin : g_lim
            assign pos_lim[gi] = (gi < W - 1);
            assign neg_lim[gi] = (gi == W - 1);
        end
        for (gi = 0; gi < W; gi++) begin : g_sat
            assign sat_pos[gi] = (gi < W - 1);
            assign sat_neg[gi] = (gi == W - 1);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Rounding, saturation and negation
    // ------------------------------------------------------------------
    logic         inexact_raw;
    logic         inc;
    logic [MW:0]  sum;
    logic         sat;
    logic [W-1:0] fin_data;
    logic [2:0]   fin_flags;

    always_comb begin
        inexact_raw = guard_reg | sticky_reg;
        inc         = 1'b0;
        case (rmode_reg)
            2'd0:    inc = guard_reg & (sticky_reg | mag_reg[0]);
            2'd2:    inc = inexact_raw & !sign_reg;
            2'd3:    inc = inexact_raw & sign_reg;
            default: inc = 1'b0;
        endcase
        // Flushed denormals report inexact but must not round away from zero.
        if (flush_reg) begin
            inc = 1'b0;
        end
        sum = {1'b0, mag_reg} + (MW+1)'(inc);
        sat = ovf_reg || (sign_reg ? (sum > neg_lim) : (sum > pos_lim));

        fin_data  = '0;
        fin_flags = 3'b000;
        if (nan_reg) begin
            fin_flags = 3'b100;
        end else if (sat) begin
            fin_data  = sign_reg ? sat_neg : sat_pos;
            fin_flags = 3'b010;
        end else begin
            fin_data  = sign_reg ? (~sum[W-1:0] + W'(1)) : sum[W-1:0];
            fin_flags = {2'b00, inexact_raw};
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (in_valid) state_next = SHIFT;
            // Special cases enter with a zero count and leave after one cycle.
            SHIFT: if (cnt_reg == '0) state_next = FINAL;
            FINAL: state_next = DONE;
            DONE:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_reg      <= 1'b0;
            rmode_reg     <= 2'd0;
            mag_reg       <= '0;
            guard_reg     <= 1'b0;
            sticky_reg    <= 1'b0;
            ovf_reg       <= 1'b0;
            nan_reg       <= 1'b0;
            flush_reg     <= 1'b0;
            left_reg      <= 1'b0;
            cnt_reg       <= '0;
            out_data_reg  <= '0;
            out_flags_reg <= 3'b000;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        sign_reg   <= in_data[31];
                        rmode_reg  <= in_rmode;
                        mag_reg    <= mag_init;
                        guard_reg  <= 1'b0;
                        sticky_reg <= sticky_init;
                        ovf_reg    <= ovf_init;
                        nan_reg    <= is_nan;
                        flush_reg  <= exp_zero || is_nan;
                        left_reg   <= (s_in > $signed(CW'(0)));
                        cnt_reg    <= shift_amt;
                    end
                end
                SHIFT: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CW'(1);
                        if (left_reg) begin
                            mag_reg <= mag_reg << 1;
                            ovf_reg <= ovf_reg | mag_reg[MW-1];
                        end else begin
                            mag_reg    <= mag_reg >> 1;
                            guard_reg  <= mag_reg[0];
                            sticky_reg <= sticky_reg | guard_reg;
                        end
                    end
                end
                FINAL: begin
                    out_data_reg  <= fin_data;
                    out_flags_reg <= fin_flags;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign out_data  = out_data_reg;
    assign out_flags = out_flags_reg;

endmodule
